// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data memory.
// Shares the memory between the CPU MEM stage and a debug/loader port and holds controls through the read-data cycle.
module dmem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic [3:0]  c_op,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic [3:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_address,
  output logic [31:0] m_din,
  output logic [3:0]  m_rwen,
  input  logic [31:0] m_dout,
  output logic        busy
);

  typedef enum logic {IDLE, RD_DATA} state_t;

  state_t      state;
  logic        last_dbg;   // 1 = debug port won the most recent grant
  logic        lat_dbg;
  logic [31:0] lat_addr;
  logic [3:0]  lat_op;

  logic        any_req, pick_d, w_ok, idle_act;
  logic [3:0]  w_op;
  logic [31:0] w_addr, w_wdata;

  // Legal access codes, including the alignment each width requires.
  function automatic logic op_legal(input logic [3:0] op, input logic [1:0] a);
    case (op)
      4'b1000, 4'b1001, 4'b0101: op_legal = 1'b1;
      4'b1010, 4'b1011, 4'b0110: op_legal = ~a[0];
      4'b1100, 4'b0111:          op_legal = (a == 2'b00);
      default:                   op_legal = 1'b0;
    endcase
  endfunction

  assign any_req  = c_req | d_req;
  assign pick_d   = d_req & (~c_req | (RR_EN && !last_dbg));
  assign w_op     = pick_d ? d_op    : c_op;
  assign w_addr   = pick_d ? d_addr  : c_addr;
  assign w_wdata  = pick_d ? d_wdata : c_wdata;
  assign w_ok     = op_legal(w_op, w_addr[1:0]);
  assign idle_act = rst_n && (state == IDLE) && any_req;
  assign busy     = (state == RD_DATA);

  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    c_gnt     = 1'b0;
    c_err     = 1'b0;
    c_rvalid  = 1'b0;
    c_rdata   = '0;
    d_gnt     = 1'b0;
    d_err     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    m_address = '0;
    m_din     = '0;
    m_rwen    = 4'b0000;
    if (idle_act) begin
      if (pick_d) begin
        d_gnt = 1'b1;
        d_err = ~w_ok;
      end else begin
        c_gnt = 1'b1;
        c_err = ~w_ok;
      end
      if (w_ok) begin
        m_address = w_addr;
        m_din     = w_wdata;
        m_rwen    = w_op;
      end
    end else if (state == RD_DATA) begin
      // Memory output depends on the held address and code, so keep driving them.
      m_address = lat_addr;
      m_rwen    = lat_op;
      if (lat_dbg) begin
        d_rvalid = 1'b1;
        d_rdata  = m_dout;
      end else begin
        c_rvalid = 1'b1;
        c_rdata  = m_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_dbg <= 1'b1;
      lat_dbg  <= 1'b0;
      lat_addr <= '0;
      lat_op   <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge view.
      case (state)
        IDLE: begin
          if (any_req) begin
            last_dbg <= pick_d;
            if (w_ok && w_op[3]) begin
              state    <= RD_DATA;
              lat_dbg  <= pick_d;
              lat_addr <= w_addr;
              lat_op   <= w_op;
            end
          end
        end
        RD_DATA: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-addressed memory model plus a table of per-cycle vectors
// and hand-written sequences for reset and pointer behaviour.
module tb_dmem_arbiter;

  localparam logic [3:0] LB = 4'b1000, LBU = 4'b1001, LHU = 4'b1011, LW = 4'b1100;
  localparam logic [3:0] SB = 4'b0101, SH = 4'b0110, SW = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, d_req;
  logic [3:0]  c_op, d_op;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err, busy;
  logic [31:0] c_rdata, d_rdata, m_address, m_din, m_dout;
  logic [3:0]  m_rwen;

  logic        c_gnt1, c_rvalid1, c_err1, d_gnt1, d_rvalid1, d_err1, busy1;
  logic [31:0] c_rdata1, d_rdata1, m_address1, m_din1;
  logic [3:0]  m_rwen1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_address(m_address), .m_din(m_din), .m_rwen(m_rwen), .m_dout(m_dout),
    .busy(busy)
  );

  dmem_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1), .c_err(c_err1),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
    .m_address(m_address1), .m_din(m_din1), .m_rwen(m_rwen1), .m_dout(32'h0),
    .busy(busy1)
  );

  // Single-port memory model: writes at the edge, read data follows the held address and code.
  logic [7:0] mem [0:1023];
  logic [9:0] ra;
  logic [31:0] word;

  assign ra = m_address[9:0];

  always @(posedge clk) begin
    case (m_rwen)
      SB: mem[ra] <= m_din[7:0];
      SH: begin mem[ra] <= m_din[7:0]; mem[ra + 10'd1] <= m_din[15:8]; end
      SW: begin
        mem[ra] <= m_din[7:0];            mem[ra + 10'd1] <= m_din[15:8];
        mem[ra + 10'd2] <= m_din[23:16];  mem[ra + 10'd3] <= m_din[31:24];
      end
      default: ;
    endcase
  end

  always_comb begin
    word   = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
    m_dout = 32'h0;
    case (m_rwen)
      LB:      m_dout = {{24{word[7]}}, word[7:0]};
      LBU:     m_dout = {24'h0, word[7:0]};
      4'b1010: m_dout = {{16{word[15]}}, word[15:0]};
      LHU:     m_dout = {16'h0, word[15:0]};
      LW:      m_dout = word;
      default: m_dout = 32'h0;
    endcase
  end

  typedef struct {
    logic        cr;
    logic [3:0]  cop;
    logic [31:0] ca, cw;
    logic        dr;
    logic [3:0]  dop;
    logic [31:0] da, dw;
    logic [2:0]  cexp;   // {gnt, err, rvalid}
    logic [31:0] crd;
    logic [2:0]  dexp;
    logic [31:0] drd;
    logic [3:0]  rwen;
    logic [31:0] ma;
    logic        bsy;
    logic        g1c, g1d; // grants expected from the fixed-priority instance
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic cr, input logic [3:0] cop, input logic [31:0] ca, input logic [31:0] cw,
                     input logic dr, input logic [3:0] dop, input logic [31:0] da, input logic [31:0] dw,
                     input logic [2:0] cexp, input logic [31:0] crd, input logic [2:0] dexp, input logic [31:0] drd,
                     input logic [3:0] rwen, input logic [31:0] ma, input logic bsy, input logic g1c, input logic g1d);
    vec_t v;
    v.cr = cr; v.cop = cop; v.ca = ca; v.cw = cw;
    v.dr = dr; v.dop = dop; v.da = da; v.dw = dw;
    v.cexp = cexp; v.crd = crd; v.dexp = dexp; v.drd = drd;
    v.rwen = rwen; v.ma = ma; v.bsy = bsy; v.g1c = g1c; v.g1d = g1d;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    c_req = 1'b0; c_op = 4'h0; c_addr = 32'h0; c_wdata = 32'h0;
    d_req = 1'b0; d_op = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    drive_idle();
    rst_n = 1'b0;

    //        c: req op   addr       wdata          d: req op     addr       wdata          c{g,e,v} c_rdata       d{g,e,v} d_rdata       rwen    m_address  bsy g1c g1d
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b000, 32'h0,        3'b000, 32'h0,        4'h0, 32'h000, 0, 0, 0);
    add(1, SW,   32'h100, 32'hDEADBEEF, 0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        SW,   32'h100, 0, 1, 0);
    add(1, LW,   32'h100, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LW,   32'h100, 0, 1, 0);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b001, 32'hDEADBEEF, 3'b000, 32'h0,        LW,   32'h100, 1, 0, 0);
    add(1, SW,   32'h104, 32'h80,       0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        SW,   32'h104, 0, 1, 0);
    add(1, LB,   32'h104, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LB,   32'h104, 0, 1, 0);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b001, 32'hFFFFFF80, 3'b000, 32'h0,        LB,   32'h104, 1, 0, 0);
    add(1, LBU,  32'h104, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LBU,  32'h104, 0, 1, 0);
    add(1, SH,   32'h106, 32'hABCD,     0, 4'h0,    32'h000, 32'h0,        3'b001, 32'h00000080, 3'b000, 32'h0,        LBU,  32'h104, 1, 0, 0);
    add(1, SH,   32'h106, 32'hABCD,     0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        SH,   32'h106, 0, 1, 0);
    add(1, LHU,  32'h106, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LHU,  32'h106, 0, 1, 0);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b001, 32'h0000ABCD, 3'b000, 32'h0,        LHU,  32'h106, 1, 0, 0);
    add(1, LW,   32'h102, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b110, 32'h0,        3'b000, 32'h0,        4'h0, 32'h000, 0, 1, 0);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b000, 32'h0,        3'b000, 32'h0,        4'h0, 32'h000, 0, 0, 0);
    add(0, 4'h0, 32'h000, 32'h0,        1, 4'b1101, 32'h000, 32'h0,        3'b000, 32'h0,        3'b110, 32'h0,        4'h0, 32'h000, 0, 0, 1);
    // both ports stream loads: round-robin alternates, fixed priority keeps the CPU
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LW,   32'h100, 0, 1, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b001, 32'hDEADBEEF, 3'b000, 32'h0,        LW,   32'h100, 1, 0, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b000, 32'h0,        3'b100, 32'h0,        LW,   32'h104, 0, 1, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b000, 32'h0,        3'b001, 32'hABCD0080, LW,   32'h104, 1, 0, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LW,   32'h100, 0, 1, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b001, 32'hDEADBEEF, 3'b000, 32'h0,        LW,   32'h100, 1, 0, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b000, 32'h0,        3'b100, 32'h0,        LW,   32'h104, 0, 1, 0);
    add(1, LW,   32'h100, 32'h0,        1, LW,      32'h104, 32'h0,        3'b000, 32'h0,        3'b001, 32'hABCD0080, LW,   32'h104, 1, 0, 0);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b000, 32'h0,        3'b000, 32'h0,        4'h0, 32'h000, 0, 0, 0);
    // debug store waits out the CPU read-data cycle
    add(1, LW,   32'h100, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b100, 32'h0,        3'b000, 32'h0,        LW,   32'h100, 0, 1, 0);
    add(0, 4'h0, 32'h000, 32'h0,        1, SW,      32'h108, 32'h12345678, 3'b001, 32'hDEADBEEF, 3'b000, 32'h0,        LW,   32'h100, 1, 0, 0);
    add(0, 4'h0, 32'h000, 32'h0,        1, SW,      32'h108, 32'h12345678, 3'b000, 32'h0,        3'b100, 32'h0,        SW,   32'h108, 0, 0, 1);
    add(0, 4'h0, 32'h000, 32'h0,        1, LW,      32'h108, 32'h0,        3'b000, 32'h0,        3'b100, 32'h0,        LW,   32'h108, 0, 0, 1);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b000, 32'h0,        3'b001, 32'h12345678, LW,   32'h108, 1, 0, 0);
    add(0, 4'h0, 32'h000, 32'h0,        0, 4'h0,    32'h000, 32'h0,        3'b000, 32'h0,        3'b000, 32'h0,        4'h0, 32'h000, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset c_out", {29'h0, c_gnt, c_err, c_rvalid}, 32'h0);
    check("reset d_out", {29'h0, d_gnt, d_err, d_rvalid}, 32'h0);
    check("reset bus", m_address | m_din | {28'h0, m_rwen} | {31'h0, busy}, 32'h0);
    check("reset rdata", c_rdata | d_rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      c_req = vq[i].cr; c_op = vq[i].cop; c_addr = vq[i].ca; c_wdata = vq[i].cw;
      d_req = vq[i].dr; d_op = vq[i].dop; d_addr = vq[i].da; d_wdata = vq[i].dw;
      @(negedge clk);
      check($sformatf("v%0d c_gnt/err/rvalid", i), {29'h0, c_gnt, c_err, c_rvalid}, {29'h0, vq[i].cexp});
      check($sformatf("v%0d c_rdata", i), c_rdata, vq[i].crd);
      check($sformatf("v%0d d_gnt/err/rvalid", i), {29'h0, d_gnt, d_err, d_rvalid}, {29'h0, vq[i].dexp});
      check($sformatf("v%0d d_rdata", i), d_rdata, vq[i].drd);
      check($sformatf("v%0d m_rwen", i), {28'h0, m_rwen}, {28'h0, vq[i].rwen});
      check($sformatf("v%0d m_address", i), m_address, vq[i].ma);
      check($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, vq[i].bsy});
      check($sformatf("v%0d fixed-prio gnt", i), {30'h0, c_gnt1, d_gnt1}, {30'h0, vq[i].g1c, vq[i].g1d});
    end

    // reset asserted in the read-data cycle drops the pending response
    @(posedge clk);
    #1;
    c_req = 1'b1; c_op = LW; c_addr = 32'h100; c_wdata = 32'h0;
    d_req = 1'b0;
    @(negedge clk);
    check("rst-seq load gnt", {31'h0, c_gnt}, 32'h1);
    @(posedge clk);
    #1;
    c_req = 1'b0;
    @(negedge clk);
    check("rst-seq rvalid before reset", {31'h0, c_rvalid}, 32'h1);
    check("rst-seq busy before reset", {31'h0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst-seq rvalid in reset", {31'h0, c_rvalid}, 32'h0);
    check("rst-seq rdata in reset", c_rdata, 32'h0);
    check("rst-seq busy in reset", {31'h0, busy}, 32'h0);
    check("rst-seq bus in reset", m_address | m_din | {28'h0, m_rwen}, 32'h0);
    c_req = 1'b1; c_op = SW; c_addr = 32'h10C; c_wdata = 32'h55;
    #1;
    check("rst-seq gnt in reset", {30'h0, c_gnt, c_err}, 32'h0);
    check("rst-seq rwen in reset", {28'h0, m_rwen}, 32'h0);
    c_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst-seq no rvalid after release %0d", k), {30'h0, c_rvalid, d_rvalid}, 32'h0);
      check($sformatf("rst-seq idle after release %0d", k), {31'h0, busy}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer placed in front of the single-port data memory. It shares the memory between the CPU MEM-stage port and a debug/loader port. Each access is issued using the memory's 4-bit `read_write_en` encoding. Because read data arrives one cycle after the address and depends on held controls, the block holds address and controls through the read-data cycle and returns the result with a valid strobe.

## Interface
Parameters:
- `RR_EN`, default 1: 1 = round-robin between ports; 0 = fixed priority, CPU always wins.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  CPU request; held with `c_op`/`c_addr`/`c_wdata` stable until `c_gnt`.
- `c_op`  in  4  access code: `{read, op[2:0]}`. Loads: 1000 LB, 1001 LBU, 1010 LH, 1011 LHU, 1100 LW. Stores: 0101 SB, 0110 SH, 0111 SW.
- `c_addr`  in  32  byte address.
- `c_wdata`  in  32  store data, LSB-aligned.
- `c_gnt`  out  1  request accepted this cycle.
- `c_rvalid`  out  1  load data valid.
- `c_rdata`  out  32  load result.
- `c_err`  out  1  1-cycle pulse: request accepted but rejected (illegal op or misaligned).
- `d_req`, `d_op`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: same as the CPU set, for the debug port.
- `m_address`  out  32  to memory `address`.
- `m_din`  out  32  to memory `D_in`.
- `m_rwen`  out  4  to memory `read_write_en`.
- `m_dout`  in  32  from memory `D_out`.
- `busy`  out  1  high in RD_DATA.

## Operation
- FSM states:
  - IDLE: memory bus idle, `m_rwen`=0000.
  - RD_DATA: holds the latched read.
- Arbitration, in IDLE only:
  - A single requester wins.
  - Both requesting with `RR_EN`=1: the port that did not win the last grant wins. The last-winner pointer resets to "debug", so the CPU wins the first tie.
  - `RR_EN`=0: the CPU wins every tie.
- Legality check on the winner, combinational:
  - Legal codes: the 8 listed above.
  - Misaligned: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠00.
  - Illegal or misaligned request: `gnt`=1 and `err`=1 this cycle, `m_rwen`=0000, no memory access, no `rvalid`, stay in IDLE.
- Legal store, in IDLE:
  - Drive `m_address`=addr, `m_din`=wdata, `m_rwen`=op, and `gnt`=1, all combinationally.
  - The memory writes at that clock edge. Stay in IDLE.
- Legal load, in IDLE:
  - Drive the bus and `gnt` as for a store.
  - Latch port id, addr and op. Go to RD_DATA.
- RD_DATA:
  - Keep driving the latched `m_address` and `m_rwen`; `m_din`=0.
  - Forward `m_dout` to the latched port's `rdata` with `rvalid`=1.
  - No grants this cycle; `gnt`=0 on both ports even if `req` is high.
  - Return to IDLE.
- `rdata` of a non-selected port, and of any port when `rvalid`=0, is 0.
- The pointer updates on every grant, including err grants.

## Timing
- Reset (async assert, `rst_n`=0):
  - State becomes IDLE and the pointer becomes "debug".
  - All `gnt`/`rvalid`/`err` = 0, all `rdata` = 0, `m_rwen`=0000, `m_address`=0, `m_din`=0, `busy`=0.
  - Reset during RD_DATA drops the pending response; no `rvalid` after reset.
- `gnt` and `err` are combinational from `req` in IDLE. The requester samples `gnt` at the edge and may change inputs afterwards.
- Store latency: write committed at the grant edge. Throughput is 1 store per cycle.
- Load latency: `rvalid` appears 1 cycle after `gnt`. Throughput is 1 load per 2 cycles.
- Load → store or load → load, either port: the next grant comes no earlier than the cycle after `rvalid`.
- Store immediately followed by a load to the same word: the load returns the new data, because the memory reads after the write edge.

## Test plan
- Reset, then CPU SW 0xDEADBEEF to 0x100, then CPU LW 0x100 → `c_gnt` each request; `c_rvalid`=1 with 0xDEADBEEF one cycle after the LW grant; `d_*` stays 0.
- Store 0x00000080 to 0x104, then LB 0x104 → 0xFFFFFF80; LBU 0x104 → 0x00000080; SH 0xABCD to 0x106 then LHU 0x106 → 0x0000ABCD.
- Both ports request LW continuously with `RR_EN`=1 → grants alternate C, D, C, D, each 2 cycles apart, each `rvalid` on the right port. With `RR_EN`=0 → CPU only; `d_gnt` stays 0.
- CPU LW to 0x102 → `c_gnt`=`c_err`=1 same cycle, `m_rwen`=0000, no `c_rvalid`. Debug op 1101 → `d_err`=1.
- Debug SW while CPU waits in RD_DATA → `d_gnt` held 0 during `busy`, granted the next cycle.
- Assert `rst_n`=0 in RD_DATA → outputs 0 immediately; no `rvalid` after release.
